// File: rtl/input_divider_ctrl.sv
// input_divider_ctrl: glitch-free reconfiguration sequencer for the input clock
// divider, with an optional edge-count frequency measurement after lock.
//   clk_i, rstb_i            controller clock, synchronous active-low reset
//   cfg_valid_i/cfg_ready_o  configuration request handshake
//   cfg_ndiv_i, cfg_bypass_div_i, cfg_bypass_div2_i  requested divider settings
//   cfg_meas_i, meas_win_i   measurement request and window length (clk cycles)
//   en_o, en_meas_o          divider enable and measurement-path gate
//   ndiv_o, bypass_div_o, bypass_div2_o  settings driven to the divider
//   out_meas_i               divider measurement output (asynchronous)
//   busy_o, done_o           sequence in progress / one-cycle end pulse
//   meas_cnt_o, meas_ovf_o   result of the last measurement
module input_divider_ctrl #(
    parameter int SETTLE_CYC = 8,
    parameter int LOCK_CYC   = 16,
    parameter int MEAS_WIN_W = 10,
    parameter int CNT_W      = 12
) (
    input  logic                  clk_i,
    input  logic                  rstb_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [2:0]            cfg_ndiv_i,
    input  logic                  cfg_bypass_div_i,
    input  logic                  cfg_bypass_div2_i,
    input  logic                  cfg_meas_i,
    input  logic [MEAS_WIN_W-1:0] meas_win_i,
    output logic                  en_o,
    output logic                  en_meas_o,
    output logic [2:0]            ndiv_o,
    output logic                  bypass_div_o,
    output logic                  bypass_div2_o,
    input  logic                  out_meas_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      meas_cnt_o,
    output logic                  meas_ovf_o
);
    typedef enum logic [2:0] {S_IDLE, S_DISABLE, S_SETTLE, S_APPLY, S_LOCK, S_MEAS, S_DONE} state_t;

    state_t                state_q;
    logic [31:0]           tmr_q;
    logic [2:0]            nd_q;
    logic                  bd_q;
    logic                  bd2_q;
    logic                  meas_q;
    logic [MEAS_WIN_W-1:0] win_q;
    logic [1:0]            sync_q;
    logic                  prev_q;
    logic [CNT_W-1:0]      ecnt_q;
    logic                  eovf_q;
    logic                  do_meas;
    logic                  rise;

    assign do_meas = meas_q && (win_q != '0);
    assign rise    = sync_q[1] & ~prev_q;

    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            nd_q          <= '0;
            bd_q          <= 1'b0;
            bd2_q         <= 1'b0;
            meas_q        <= 1'b0;
            win_q         <= '0;
            sync_q        <= '0;
            prev_q        <= 1'b0;
            ecnt_q        <= '0;
            eovf_q        <= 1'b0;
            cfg_ready_o   <= 1'b1;
            en_o          <= 1'b0;
            en_meas_o     <= 1'b0;
            ndiv_o        <= '0;
            bypass_div_o  <= 1'b1;
            bypass_div2_o <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            meas_cnt_o    <= '0;
            meas_ovf_o    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], out_meas_i};
            prev_q <= sync_q[1];
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid_i) begin
                        nd_q        <= cfg_ndiv_i;
                        bd_q        <= cfg_bypass_div_i;
                        bd2_q       <= cfg_bypass_div2_i;
                        meas_q      <= cfg_meas_i;
                        win_q       <= meas_win_i;
                        cfg_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        en_o        <= 1'b0;
                        state_q     <= S_DISABLE;
                    end
                end
                S_DISABLE: begin
                    tmr_q   <= 32'(SETTLE_CYC - 1);
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (tmr_q == '0) begin
                        // settings only ever move here, with the divider held off
                        ndiv_o        <= nd_q;
                        bypass_div_o  <= bd_q;
                        bypass_div2_o <= bd2_q;
                        state_q       <= S_APPLY;
                    end else begin
                        tmr_q <= tmr_q - 32'd1;
                    end
                end
                S_APPLY: begin
                    en_o    <= 1'b1;
                    tmr_q   <= 32'(LOCK_CYC - 1);
                    state_q <= S_LOCK;
                end
                S_LOCK: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 32'd1;
                    end else if (do_meas) begin
                        en_meas_o <= 1'b1;
                        ecnt_q    <= '0;
                        eovf_q    <= 1'b0;
                        tmr_q     <= 32'(win_q) - 32'd1;
                        state_q   <= S_MEAS;
                    end else begin
                        done_o  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        if (ecnt_q == '1) eovf_q <= 1'b1;
                        else ecnt_q <= ecnt_q + 1'b1;
                    end
                    if (tmr_q == '0) begin
                        en_meas_o <= 1'b0;
                        done_o    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        tmr_q <= tmr_q - 32'd1;
                    end
                end
                S_DONE: begin
                    if (do_meas) begin
                        meas_cnt_o <= ecnt_q;
                        meas_ovf_o <= eovf_q;
                    end
                    done_o      <= 1'b0;
                    busy_o      <= 1'b0;
                    cfg_ready_o <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_divider_ctrl.sv
// tb_input_divider_ctrl: directed bench for input_divider_ctrl.
module tb_input_divider_ctrl;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_ndiv = '0;
    logic        cfg_bypass_div = 1'b0;
    logic        cfg_bypass_div2 = 1'b0;
    logic        cfg_meas = 1'b0;
    logic [9:0]  meas_win = '0;
    logic        out_meas = 1'b0;
    logic        cfg_ready, en, en_meas, bypass_div, bypass_div2, busy, done, meas_ovf;
    logic [2:0]  ndiv;
    logic [11:0] meas_cnt;
    logic        s_ready, s_en, s_en_meas, s_bd, s_bd2, s_busy, s_done, s_ovf;
    logic [2:0]  s_ndiv;
    logic [3:0]  s_cnt;
    int          n_chk = 0;
    int          n_pass = 0;
    int          half_per = 0;
    int          bad = 0;
    int          dcyc, erise, mcyc, ndone, chg, rdy, saved, cnt;

    always #5 clk = ~clk;

    initial begin
        #3;
        forever begin
            if (half_per == 0) #10;
            else begin
                #(half_per * 10);
                out_meas = ~out_meas;
            end
        end
    end

    input_divider_ctrl dut (
        .clk_i(clk), .rstb_i(rstb), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_ndiv_i(cfg_ndiv), .cfg_bypass_div_i(cfg_bypass_div), .cfg_bypass_div2_i(cfg_bypass_div2),
        .cfg_meas_i(cfg_meas), .meas_win_i(meas_win), .en_o(en), .en_meas_o(en_meas),
        .ndiv_o(ndiv), .bypass_div_o(bypass_div), .bypass_div2_o(bypass_div2),
        .out_meas_i(out_meas), .busy_o(busy), .done_o(done), .meas_cnt_o(meas_cnt), .meas_ovf_o(meas_ovf)
    );

    input_divider_ctrl #(.CNT_W(4)) dut_s (
        .clk_i(clk), .rstb_i(rstb), .cfg_valid_i(cfg_valid), .cfg_ready_o(s_ready),
        .cfg_ndiv_i(cfg_ndiv), .cfg_bypass_div_i(cfg_bypass_div), .cfg_bypass_div2_i(cfg_bypass_div2),
        .cfg_meas_i(cfg_meas), .meas_win_i(meas_win), .en_o(s_en), .en_meas_o(s_en_meas),
        .ndiv_o(s_ndiv), .bypass_div_o(s_bd), .bypass_div2_o(s_bd2),
        .out_meas_i(out_meas), .busy_o(s_busy), .done_o(s_done), .meas_cnt_o(s_cnt), .meas_ovf_o(s_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic run(input logic [2:0] nd, input logic bd, input logic bd2, input logic m,
                       input logic [9:0] w, input logic spam);
        logic [4:0] prev;
        prev = {ndiv, bypass_div, bypass_div2};
        cfg_ndiv = nd;
        cfg_bypass_div = bd;
        cfg_bypass_div2 = bd2;
        cfg_meas = m;
        meas_win = w;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        dcyc = -1; erise = -1; chg = -1; mcyc = 0; ndone = 0; rdy = -1;
        for (int c = 1; c < 1000; c++) begin
            if (erise < 0 && en) erise = c;
            if (chg < 0 && {ndiv, bypass_div, bypass_div2} != prev) chg = c;
            if (en_meas) mcyc++;
            if (busy && cfg_ready) bad++;
            if (done) begin ndone++; dcyc = c; end
            if (dcyc >= 0 && c == dcyc + 1) rdy = int'(cfg_ready);
            if (dcyc >= 0 && c >= dcyc + 3) break;
            cfg_valid = spam && dcyc < 0 && (c % 2 == 0);
            if (spam) begin
                cfg_ndiv = 3'd7;
                cfg_bypass_div = ~bd;
                cfg_bypass_div2 = ~bd2;
                cfg_meas = 1'b1;
                meas_win = 10'd50;
            end
            tick;
        end
        cfg_valid = 1'b0;
        chk("seq_finished", int'(dcyc >= 0), 1);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_en", en, 0);
        chk("rst_en_meas", en_meas, 0);
        chk("rst_ndiv", ndiv, 0);
        chk("rst_bypass", {bypass_div, bypass_div2}, 3);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_meas", {meas_ovf, meas_cnt}, 0);
        rstb = 1'b1;
        tick;
        chk("ready_after_rst", cfg_ready, 1);

        run(3'd3, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
        chk("t1_cfg_change_cyc", chg, 10);
        chk("t1_en_rise_cyc", erise, 11);
        chk("t1_done_cyc", dcyc, 27);
        chk("t1_ready_after", rdy, 1);
        chk("t1_cfg", {ndiv, bypass_div, bypass_div2}, {3'd3, 2'b01});
        chk("t1_en_held", en, 1);

        half_per = 5;
        run(3'd1, 1'b1, 1'b0, 1'b1, 10'd200, 1'b0);
        half_per = 0;
        chk("t2_done_cyc", dcyc, 227);
        chk("t2_meas_cycles", mcyc, 200);
        chk("t2_cnt_range", int'(meas_cnt >= 19 && meas_cnt <= 21), 1);
        chk("t2_ovf", meas_ovf, 0);

        half_per = 2;
        run(3'd2, 1'b0, 1'b0, 1'b1, 10'd100, 1'b0);
        half_per = 0;
        chk("t3_done_cyc", dcyc, 127);
        chk("t3_cnt_range", int'(meas_cnt >= 24 && meas_cnt <= 26), 1);
        chk("t3_ovf", meas_ovf, 0);
        chk("t3_sat_cnt", s_cnt, 15);
        chk("t3_sat_ovf", s_ovf, 1);
        chk("t3_s_state", {s_ready, s_busy, s_done, s_en, s_en_meas}, 5'b10010);
        chk("t3_s_cfg", {s_ndiv, s_bd, s_bd2}, {3'd2, 2'b00});

        saved = meas_cnt;
        run(3'd4, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0);
        chk("t6_meas_cycles", mcyc, 0);
        chk("t6_done_cyc", dcyc, 27);
        chk("t6_cnt_kept", meas_cnt, saved);
        chk("t6_sat_kept", {s_ovf, s_cnt}, 5'h1f);

        run(3'd5, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1);
        chk("t4_one_done", ndone, 1);
        chk("t4_done_cyc", dcyc, 27);
        chk("t4_cfg_first", {ndiv, bypass_div, bypass_div2}, {3'd5, 2'b10});
        chk("t4_no_meas", mcyc, 0);
        chk("ready_never_busy", bad, 0);

        cfg_ndiv = 3'd2;
        cfg_bypass_div = 1'b0;
        cfg_bypass_div2 = 1'b0;
        cfg_meas = 1'b0;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        for (int c = 1; c < 15; c++) tick;
        chk("t5_in_lock", {en, busy}, 2'b11);
        rstb = 1'b0;
        tick;
        chk("t5_rst_en", en, 0);
        chk("t5_rst_cfg", {ndiv, bypass_div, bypass_div2}, {3'd0, 2'b11});
        chk("t5_rst_busy_done", {busy, done}, 0);
        chk("t5_rst_meas", meas_cnt, 0);
        rstb = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (done) cnt++;
        end
        chk("t5_no_done", cnt, 0);
        chk("t5_idle_ready", cfg_ready, 1);
        run(3'd6, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
        chk("t5_after_done_cyc", dcyc, 27);
        chk("t5_after_cfg", {ndiv, bypass_div, bypass_div2}, {3'd6, 2'b01});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
